// File: rtl/riscv_pkg.sv
// Shared RISC-V integer datapath constants and types for the register file slice.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/regs_scoreboard.sv
// Per-register busy scoreboard: issue sets, completed writes clear, set wins on overlap.
module regs_scoreboard #(
    parameter int NREGS  = riscv_pkg::NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_valid,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_a_valid,
    input  logic [AW-1:0] clr_a_rd,
    input  logic          clr_b_valid,
    input  logic [AW-1:0] clr_b_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (set_valid && set_rd == AW'(i))
                w_busy_nxt[i] = 1'b1;
            else if ((clr_a_valid && clr_a_rd == AW'(i)) ||
                     (clr_b_valid && clr_b_rd == AW'(i)))
                w_busy_nxt[i] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // A write completing this cycle hides the stale busy bit, unless a new producer claims it.
    function automatic logic f_busy(input logic [AW-1:0] a);
        logic v;
        v = r_busy[a];
        if (BYPASS &&
            ((clr_a_valid && clr_a_rd == a) || (clr_b_valid && clr_b_rd == a)) &&
            !(set_valid && set_rd == a))
            v = 1'b0;
        if (!rst_n || a == '0)
            v = 1'b0;
        return v;
    endfunction

    always_comb rs1_busy = f_busy(rs1);
    always_comb rs2_busy = f_busy(rs2);

endmodule

// File: rtl/regs_file_bypass_sb.sv
// Two-write-port integer register file with optional write-to-read bypass and busy scoreboard.
module regs_file_bypass_sb #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREGS  = riscv_pkg::NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] r_data1,
    output logic [XLEN-1:0] r_data2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wa_valid,
    input  logic [AW-1:0]   wa_rd,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready
);

    logic [NREGS-1:0][XLEN-1:0] r_mem;
    logic                       w_wa_we;
    logic                       w_wb_xfer;
    logic                       w_wb_we;

    assign w_wa_we   = wa_valid && (wa_rd != '0);
    // Port A wins a same-rd collision; port B holds its request until the next free cycle.
    assign wb_ready  = !(w_wa_we && (wa_rd == wb_rd));
    assign w_wb_xfer = wb_valid && wb_ready;
    assign w_wb_we   = w_wb_xfer && (wb_rd != '0);

    // Entry 0 is never written, so it reads back as zero even without the address check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else begin
            if (w_wa_we)
                r_mem[wa_rd] <= wa_data;
            if (w_wb_we)
                r_mem[wb_rd] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = r_mem[a];
        if (BYPASS) begin
            if (w_wa_we && wa_rd == a)
                v = wa_data;
            else if (w_wb_we && wb_rd == a)
                v = wb_data;
        end
        if (!rst_n || a == '0)
            v = '0;
        return v;
    endfunction

    always_comb r_data1 = f_read(rs1);
    always_comb r_data2 = f_read(rs2);

    regs_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid   (iss_valid),
        .set_rd      (iss_rd),
        .clr_a_valid (w_wa_we),
        .clr_a_rd    (wa_rd),
        .clr_b_valid (w_wb_we),
        .clr_b_rd    (wb_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_regs_file_bypass_sb.sv
// Scoreboard bench: bypass and non-bypass instances share stimulus; a reference model predicts every cycle.
module tb_regs_file_bypass_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0]   rs1, rs2, iss_rd, wa_rd, wb_rd;
    logic            iss_valid, wa_valid, wb_valid;
    logic [XLEN-1:0] wa_data, wb_data;

    logic [XLEN-1:0] d1_b, d2_b, d1_n, d2_n;
    logic            b1_b, b2_b, b1_n, b2_n, rdy_b, rdy_n;

    regs_file_bypass_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)) u_bp (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .r_data1(d1_b), .r_data2(d2_b), .rs1_busy(b1_b), .rs2_busy(b2_b),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wa_valid(wa_valid), .wa_rd(wa_rd), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(rdy_b)
    );

    regs_file_bypass_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .r_data1(d1_n), .r_data2(d2_n), .rs1_busy(b1_n), .rs2_busy(b2_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wa_valid(wa_valid), .wa_rd(wa_rd), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(rdy_n)
    );

    typedef struct {
        logic            iss_v;
        logic [AW-1:0]   iss_rd;
        logic            wa_v;
        logic [AW-1:0]   wa_rd;
        logic [XLEN-1:0] wa_d;
        logic            wb_v;
        logic [AW-1:0]   wb_rd;
        logic [XLEN-1:0] wb_d;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
    } stim_t;

    typedef struct {
        logic [XLEN-1:0] d1b, d2b, d1n, d2n;
        logic            b1b, b2b, b1n, b2n, rdy;
    } exp_t;

    exp_t            q[$];
    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_busy[NREGS];
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic stim_t idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        stim_t s;
        s = '{default: '0};
        s.rs1 = a1;
        s.rs2 = a2;
        return s;
    endfunction

    // Reference model: architectural registers plus a busy set, evaluated from the rules directly.
    function automatic logic m_ready(input stim_t s);
        return !(s.wa_v && s.wa_rd != 0 && s.wa_rd == s.wb_rd);
    endfunction

    function automatic logic [XLEN-1:0] m_read(input stim_t s, input logic [AW-1:0] a, input bit bp);
        if (!rst_n || a == 0) return '0;
        if (bp && s.wa_v && s.wa_rd == a) return s.wa_d;
        if (bp && s.wb_v && m_ready(s) && s.wb_rd == a) return s.wb_d;
        return m_reg[a];
    endfunction

    function automatic logic m_busy_rd(input stim_t s, input logic [AW-1:0] a, input bit bp);
        bit wr, st;
        if (!rst_n || a == 0) return 1'b0;
        wr = (s.wa_v && s.wa_rd == a) || (s.wb_v && m_ready(s) && s.wb_rd == a);
        st = s.iss_v && s.iss_rd == a;
        if (bp && wr && !st) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_step(input stim_t s);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (s.wa_v && s.wa_rd != 0) begin
                m_reg[s.wa_rd]  = s.wa_d;
                m_busy[s.wa_rd] = 1'b0;
            end
            if (s.wb_v && m_ready(s) && s.wb_rd != 0) begin
                m_reg[s.wb_rd]  = s.wb_d;
                m_busy[s.wb_rd] = 1'b0;
            end
            if (s.iss_v && s.iss_rd != 0)
                m_busy[s.iss_rd] = 1'b1;
        end
    endtask

    task automatic drive(input stim_t s);
        iss_valid = s.iss_v; iss_rd = s.iss_rd;
        wa_valid  = s.wa_v;  wa_rd  = s.wa_rd; wa_data = s.wa_d;
        wb_valid  = s.wb_v;  wb_rd  = s.wb_rd; wb_data = s.wb_d;
        rs1       = s.rs1;   rs2    = s.rs2;
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(negedge clk);
        drive(s);
        #1;
        e.d1b = m_read(s, s.rs1, 1'b1);  e.d2b = m_read(s, s.rs2, 1'b1);
        e.d1n = m_read(s, s.rs1, 1'b0);  e.d2n = m_read(s, s.rs2, 1'b0);
        e.b1b = m_busy_rd(s, s.rs1, 1'b1); e.b2b = m_busy_rd(s, s.rs2, 1'b1);
        e.b1n = m_busy_rd(s, s.rs1, 1'b0); e.b2n = m_busy_rd(s, s.rs2, 1'b0);
        e.rdy = m_ready(s);
        q.push_back(e);
        @(posedge clk);
        model_step(s);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
    task automatic async_reset(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        stim_t s;
        s = idle(a1, a2);
        @(negedge clk);
        drive(s);
        @(posedge clk);
        model_step(s);
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_rst_d1_bp", d1_b, '0);  chk("async_rst_d2_bp", d2_b, '0);
        chk("async_rst_d1_nb", d1_n, '0);  chk("async_rst_d2_nb", d2_n, '0);
        chk("async_rst_b1_bp", b1_b, '0);  chk("async_rst_b2_bp", b2_b, '0);
        chk("async_rst_b1_nb", b1_n, '0);  chk("async_rst_b2_nb", b2_n, '0);
        cyc(s);
        #2 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd1_bp", d1_b, e.d1b);   chk("rd2_bp", d2_b, e.d2b);
                chk("rd1_nb", d1_n, e.d1n);   chk("rd2_nb", d2_n, e.d2n);
                chk("busy1_bp", b1_b, e.b1b); chk("busy2_bp", b2_b, e.b2b);
                chk("busy1_nb", b1_n, e.b1n); chk("busy2_nb", b2_n, e.b2n);
                chk("wb_ready_bp", rdy_b, e.rdy);
                chk("wb_ready_nb", rdy_n, e.rdy);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        bit              b_pend;
        logic [AW-1:0]   b_rd;
        logic [XLEN-1:0] b_d;

        rst_n = 1'b0;
        model_clear();
        drive(idle(5'd5, 5'd31));
        repeat (2) cyc(idle(5'd5, 5'd31));
        #2 rst_n = 1'b1;

        // Preload x5/x31 and mark x5 busy, then prove an async reset wipes them.
        s = idle(5'd5, 5'd31);
        s.wa_v = 1; s.wa_rd = 5'd5; s.wa_d = 32'h0000_0055;
        s.wb_v = 1; s.wb_rd = 5'd31; s.wb_d = 32'h3131_3131;
        cyc(s);
        s = idle(5'd5, 5'd31); s.iss_v = 1; s.iss_rd = 5'd5;
        cyc(s);
        cyc(idle(5'd5, 5'd31));
        async_reset(5'd5, 5'd31);
        cyc(idle(5'd5, 5'd31));

        // x0 stays zero and never busy.
        s = idle(5'd0, 5'd0);
        s.wa_v = 1; s.wa_rd = 5'd0; s.wa_d = 32'hDEAD_BEEF;
        s.wb_v = 1; s.wb_rd = 5'd0; s.wb_d = 32'hDEAD_BEEF;
        s.iss_v = 1; s.iss_rd = 5'd0;
        cyc(s);
        cyc(idle(5'd0, 5'd0));

        // Same-rd collision, then B retries; then a different-rd pair.
        s = idle(5'd7, 5'd8);
        s.wa_v = 1; s.wa_rd = 5'd7; s.wa_d = 32'h11;
        s.wb_v = 1; s.wb_rd = 5'd7; s.wb_d = 32'h22;
        cyc(s);
        s.wa_v = 0;
        cyc(s);
        cyc(idle(5'd7, 5'd8));
        s = idle(5'd8, 5'd10);
        s.wa_v = 1; s.wa_rd = 5'd8;  s.wa_d = 32'h88;
        s.wb_v = 1; s.wb_rd = 5'd10; s.wb_d = 32'h1010;
        cyc(s);
        cyc(idle(5'd8, 5'd10));

        // Same-cycle bypass on both read ports.
        s = idle(5'd3, 5'd3);
        s.wa_v = 1; s.wa_rd = 5'd3; s.wa_d = 32'hA5A5_A5A5;
        cyc(s);
        cyc(idle(5'd3, 5'd3));

        // Scoreboard: set, clear by B, then set racing an A clear.
        s = idle(5'd9, 5'd9); s.iss_v = 1; s.iss_rd = 5'd9;
        cyc(s);
        cyc(idle(5'd9, 5'd9));
        s = idle(5'd9, 5'd9); s.wb_v = 1; s.wb_rd = 5'd9; s.wb_d = 32'h99;
        cyc(s);
        cyc(idle(5'd9, 5'd9));
        s = idle(5'd9, 5'd9);
        s.iss_v = 1; s.iss_rd = 5'd9;
        s.wa_v = 1;  s.wa_rd = 5'd9; s.wa_d = 32'h999;
        cyc(s);
        cyc(idle(5'd9, 5'd9));

        // Random traffic; port B holds its request until accepted.
        b_pend = 0; b_rd = '0; b_d = '0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                async_reset(b_rd, wa_rd);
                b_pend = 0;
            end
            s = idle('0, '0);
            s.iss_v = ($urandom % 4) == 0;
            s.iss_rd = AW'($urandom);
            s.wa_v  = ($urandom % 2) == 0;
            s.wa_rd = (($urandom % 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            s.wa_d  = $urandom;
            if (!b_pend && ($urandom % 5) < 2) begin
                b_pend = 1;
                b_rd   = (($urandom % 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                b_d    = $urandom;
            end
            s.wb_v = b_pend; s.wb_rd = b_rd; s.wb_d = b_d;
            case ($urandom % 4)
                0: s.rs1 = s.wa_rd;
                1: s.rs1 = s.wb_rd;
                2: s.rs1 = s.iss_rd;
                default: s.rs1 = AW'($urandom);
            endcase
            s.rs2 = (($urandom % 2) == 0) ? s.wb_rd : AW'($urandom);
            cyc(s);
            if (b_pend && m_ready(s))
                b_pend = 0;
        end

        repeat (3) @(negedge clk);
        #6;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regs_file_bypass_sb.md
# regs_file_bypass_sb

Parametrised successor of the single-write register file: a RISC-V integer register file with two write ports (ALU writeback and load-return), optional write-to-read bypass, and a per-register busy scoreboard. It sits between decode/issue and the writeback stage. It supplies operands and busy flags to the hazard unit and accepts results from two independent producers. x0 is hard-wired to zero, is never busy, and ignores all writes.

## Interface
- `XLEN`, 32, register width in bits.
- `NREGS`, 32, number of architectural registers (power of two, ≥ 2).
- `AW`, `$clog2(NREGS)`, register address width (derived; do not override).
- `BYPASS`, 1, 1 = same-cycle write data forwarded to read ports; 0 = write visible next cycle.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `rs1`, `rs2`  in  AW each  read addresses.
- `r_data1`, `r_data2`  out  XLEN each  combinational read data.
- `rs1_busy`, `rs2_busy`  out  1 each  combinational scoreboard state of rs1/rs2.
- `iss_valid`  in  1  issue of an instruction that writes `iss_rd`.
- `iss_rd`  in  AW  destination of the issuing instruction.
- `wa_valid`  in  1  port A (ALU) write request.
- `wa_rd`  in  AW  port A destination.
- `wa_data`  in  XLEN  port A data.
- `wb_valid`  in  1  port B (load-return) write request.
- `wb_rd`  in  AW  port B destination.
- `wb_data`  in  XLEN  port B data.
- `wb_ready`  out  1  port B accepted this cycle.

## Operation
- Port A always accepts. A write takes effect when `wa_valid` is high and `wa_rd != 0`.
- Port B handshake: transfer occurs when `wb_valid && wb_ready`.
- `wb_ready = !(wa_valid && wa_rd == wb_rd && wa_rd != 0)`. A port B write to x0 is accepted and discarded.
- On a same-rd collision, port A writes and port B is held. Port B must keep `wb_valid`, `wb_rd` and `wb_data` stable until accepted.
- Read: `r_dataN = 0` if `rsN == 0`.
- With `BYPASS=1`, read priority is:
  - port A data if `wa_valid && wa_rd == rsN`;
  - otherwise port B data if a port B transfer occurs and `wb_rd == rsN`;
  - otherwise the array.
- With `BYPASS=0`, reads come from the array only.
- Scoreboard, one `busy` bit per register. Bit 0 is constant 0.
  - Set: `iss_valid && iss_rd != 0`.
  - Clear: a completed write (A, or accepted B) to that register.
  - Set and clear to the same register in one cycle: set wins, because the new producer supersedes.
- `rsN_busy = busy[rsN]`. With `BYPASS=1` it is forced to 0 when a completed write to `rsN` occurs this cycle, unless the same cycle also sets `rsN`.
- Writes to a non-busy register are legal; they update data only.
- Reset (`rst_n` low, asynchronous): all registers = 0, all busy = 0.
  - Outputs during reset: `r_data*` = 0, `rs*_busy` = 0.
  - `wb_ready` stays combinational per its equation.
- Reset released mid-operation: no pending state survives. Producers are re-synchronised by the pipeline flush.

## Timing
- Read data and busy flags: 0-cycle combinational from addresses and the write/issue ports.
- Array write: visible through the array path 1 cycle after the write edge.
- Busy set by issue: `rsN_busy` asserts the cycle after `iss_valid`.
- `wb_ready`: combinational from port A. Port B latency is 0 when there is no collision, and +1 cycle per colliding port A write.
- No combinational path from `wb_valid` to `wb_ready`.
- Reset assertion clears state immediately, without waiting for a clock. Deassertion takes effect at the next edge.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NREGS`, `REG_AW`, constant `REG_ZERO = '0`, typedefs `reg_addr_t` and `xlen_t`.
- Sub-module `regs_scoreboard`: busy vector, set/clear priority and busy read ports. It is parametrised by `NREGS`.
- The top level holds the data array, port B arbitration and bypass muxing.

## Test plan
- Reset then read: assert `rst_n=0` mid-cycle, read x5 and x31 → data `0x0`, busy 0, with no clock edge needed.
- x0 protection: write `0xDEADBEEF` to x0 on both ports, issue to x0 → x0 reads 0 and is never busy; `wb_ready=1`.
- Collision: A writes x7=`0x11`, B writes x7=`0x22` in the same cycle → `wb_ready=0`, x7=`0x11`. Next cycle B is accepted and x7=`0x22`. A different-rd pair in one cycle writes both.
- Bypass: `BYPASS=1`, `rs1=rs2=x3`, A writes x3=`0xA5A5A5A5` → both reads return `0xA5A5A5A5` the same cycle. With `BYPASS=0`, the old value is returned that cycle and the new value next cycle.
- Scoreboard: issue x9 → `rs1_busy(x9)=1` next cycle. B write to x9 clears it. Issue x9 plus an A write to x9 in the same cycle → busy stays 1.
- Random: 10k cycles of random issue/A/B traffic against a reference model → data, busy and `wb_ready` match every cycle.
